aer_spike_encoder: RTL
======================

AER_SPIKE_ENCODER -- requirements
Module: aer_spike_encoder

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of spike inputs (2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of two).
REQ-003 SHALL have parameter TS_WIDTH, default 8, timestamp width.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port spike_in, input, N_NEURONS, one-cycle spike pulses from neuron array.
REQ-007 SHALL have port ev_valid, output, 1, FIFO head event available.
REQ-008 SHALL have port ev_ready, input, 1, consumer accepts head event.
REQ-009 SHALL have port ev_addr, output, clog2(N_NEURONS), neuron index of head event.
REQ-010 SHALL have port ev_ts, output, TS_WIDTH, timestamp of head event.
REQ-011 SHALL have port drop_cnt, output, 8, saturating count of lost spikes.
REQ-012 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, current occupancy.

Function
REQ-013 SHALL run a free-running timestamp counter incremented every cycle, wrapping modulo 2^TS_WIDTH.
REQ-014 SHALL, on spike_in[i]=1, set pending[i] and store the current counter value in ts_buf[i], same edge.
REQ-015 SHALL, if spike_in[i]=1 while pending[i] already set and not granted that cycle, keep the old ts_buf[i] and increment drop_cnt.
REQ-016 SHALL grant at most one pending neuron per cycle via round-robin, starting search at last grant +1, wrapping at N_NEURONS-1 to 0.
REQ-017 SHALL grant only when FIFO not full or a pop occurs in the same cycle; no grant -> pending unchanged.
REQ-018 SHALL, on grant of i, write {i, ts_buf[i]} to FIFO and clear pending[i]; simultaneous new spike on i re-sets pending[i] with new timestamp, no drop.
REQ-019 SHALL have minimum latency spike_in -> ev_valid of 2 cycles (latch, grant/write), FIFO initially empty.
REQ-020 SHALL pop FIFO head when ev_valid && ev_ready; ev_addr/ev_ts SHALL hold stable while ev_valid && !ev_ready.
REQ-021 SHALL support simultaneous push and pop at full and at empty-with-write; fifo_level unchanged when both occur.
REQ-022 SHALL saturate drop_cnt at 255.
REQ-023 SHALL emit events FIFO-ordered; per-neuron order preserved.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear pending, ts_buf, counter, FIFO pointers, drop_cnt, round-robin pointer (last grant = N_NEURONS-1).
REQ-025 SHALL drive ev_valid=0, ev_addr=0, ev_ts=0, drop_cnt=0, fifo_level=0 during reset; in-flight events lost.

Configuration
REQ-026 SHALL, with AER_TIMESTAMP_EN defined, implement counter, ts_buf and ev_ts as above.
REQ-027 SHALL, without AER_TIMESTAMP_EN, omit counter and ts_buf, tie ev_ts to 0, FIFO width = address only; all other behaviour identical.

Structure
REQ-028 SHALL place event record typedef (addr, ts), default widths and drop-counter max in shared package snn_pkg.
REQ-029 SHALL instantiate one sub-module aer_event_fifo (synchronous FIFO, full/empty/level); arbiter and pending logic inline.

Verification
REQ-030 Single spike_in=4'b0010 at cycle 10, ev_ready=1 -> ev_valid at cycle 12, ev_addr=1, ev_ts=10.
REQ-031 spike_in=4'b1111 one cycle, ev_ready=1 -> four events addr 0,1,2,3 on consecutive cycles, identical ts.
REQ-032 ev_ready=0, spike each neuron repeatedly 20 cycles -> fifo_level=8, ev_valid stays 1, head stable, drop_cnt>0.
REQ-033 spike_in[2] on two consecutive cycles with FIFO full -> second counted: drop_cnt +1, later event ts = first spike time.
REQ-034 Counter at 255, spike -> ev_ts=255; next spike one cycle later -> ev_ts=0 (wrap).
REQ-035 rst_n low while fifo_level=5 and pending nonzero -> ev_valid=0, fifo_level=0, drop_cnt=0 immediately; no stale event after release.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN definitions: default encoder widths, drop-counter ceiling and the AER event record.
package snn_pkg;

    localparam int N_NEURONS_DEF  = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int TS_WIDTH_DEF   = 8;
    localparam int ADDR_WIDTH_DEF = $clog2(N_NEURONS_DEF);

    localparam logic [7:0] DROP_CNT_MAX = 8'd255;

    // One address-event at the default widths: which neuron fired and when.
    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [TS_WIDTH_DEF-1:0]   ts;
    } aer_event_t;

    // Adds several lost spikes at once and clamps at the counter ceiling.
    function automatic logic [7:0] sat_add_drop(input logic [7:0] cnt, input int unsigned inc);
        int unsigned sum;
        sum = 32'(cnt) + inc;
        return (sum > 32'(DROP_CNT_MAX)) ? DROP_CNT_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous event FIFO with full/empty/level; head data reads as zero while empty.
module aer_event_fifo #(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PTR_W:0]    level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;
    logic              do_push;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/aer_spike_encoder.sv
// AER spike encoder: latches neuron spikes, round-robin arbitrates them into an event FIFO.
// Build macro AER_TIMESTAMP_EN adds a free-running timestamp to every event.
module aer_spike_encoder
    import snn_pkg::*;
#(
    parameter int  N_NEURONS  = N_NEURONS_DEF,
    parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int  TS_WIDTH   = TS_WIDTH_DEF,
    localparam int ADDR_W     = $clog2(N_NEURONS),
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [ADDR_W-1:0]    ev_addr,
    output logic [TS_WIDTH-1:0]  ev_ts,
    output logic [7:0]           drop_cnt,
    output logic [LEVEL_W-1:0]   fifo_level
);

`ifdef AER_TIMESTAMP_EN
    localparam int DATA_W = ADDR_W + TS_WIDTH;
`else
    localparam int DATA_W = ADDR_W;
`endif

    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [N_NEURONS-1:0] grant_vec;
    logic [N_NEURONS-1:0] drop_vec;
    logic [ADDR_W-1:0]    last_q, last_d;
    logic [ADDR_W-1:0]    grant_idx;
    logic                 grant_valid;
    logic                 can_grant;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           drop_q, drop_d;
    logic [DATA_W-1:0]    push_data;
    logic [DATA_W-1:0]    head_data;

    assign ev_valid  = !fifo_empty;
    assign pop       = ev_valid && ev_ready;
    assign can_grant = !fifo_full || pop;

    // Round-robin search starting one past the previous grant.
    always_comb begin
        logic [ADDR_W:0]   sum;
        logic [ADDR_W-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        sum         = '0;
        idx         = '0;
        for (int off = 1; off <= N_NEURONS; off++) begin
            sum = {1'b0, last_q} + (ADDR_W+1)'(off);
            if (sum >= (ADDR_W+1)'(N_NEURONS)) sum = sum - (ADDR_W+1)'(N_NEURONS);
            idx = sum[ADDR_W-1:0];
            if (can_grant && !grant_valid && pending_q[idx]) begin
                grant_valid    = 1'b1;
                grant_idx      = idx;
                grant_vec[idx] = 1'b1;
            end
        end
    end

    // A spike is lost only if its neuron is still waiting and not being drained this cycle.
    assign drop_vec  = spike_in & pending_q & ~grant_vec;
    assign pending_d = (pending_q & ~grant_vec) | spike_in;
    assign last_d    = grant_valid ? grant_idx : last_q;
    assign drop_d    = sat_add_drop(drop_q, 32'($countones(drop_vec)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            last_q    <= ADDR_W'(N_NEURONS - 1);
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            last_q    <= last_d;
            drop_q    <= drop_d;
        end
    end

    assign drop_cnt = drop_q;

`ifdef AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]  ts_q;
    logic [TS_WIDTH-1:0]  ts_buf_q [N_NEURONS];
    logic [N_NEURONS-1:0] ts_load;

    assign ts_load = spike_in & ~drop_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) ts_buf_q[i] <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (ts_load[i]) ts_buf_q[i] <= ts_q;
            end
        end
    end

    assign push_data = {grant_idx, ts_buf_q[grant_idx]};
    assign ev_ts     = head_data[TS_WIDTH-1:0];
`else
    assign push_data = grant_idx;
    assign ev_ts     = '0;
`endif

    assign ev_addr = head_data[DATA_W-1 -: ADDR_W];

    aer_event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (grant_valid),
        .pop_i   (pop),
        .wdata_i (push_data),
        .rdata_o (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

endmodule
